// File: rtl/matrix_io_pkg.sv
// Shared types for the matrix I/O controller: state encoding, phase codes
// and a width helper used by the controller and its dwell timer.
package matrix_io_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DISPLAY = 2'd2
  } state_e;

  localparam logic [1:0] PHASE_LOAD    = 2'd0;
  localparam logic [1:0] PHASE_COMPUTE = 2'd1;
  localparam logic [1:0] PHASE_DISPLAY = 2'd2;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_io_ctrl_dwell_timer.sv
// Dwell timer: down-counter reloaded with dwell_cycles_p-1. expired_o pulses
// on the last cycle of each dwell (or early when end_i is raised), and the
// counter reloads on that same edge so back-to-back dwells are gapless.
module dwell_timer
  import matrix_io_pkg::*;
#(
  parameter int dwell_cycles_p = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en_i,
  input  logic clear_i,
  input  logic end_i,
  output logic expired_o
);

  localparam int cnt_w_lp = clog2_min1(dwell_cycles_p);
  localparam logic [cnt_w_lp-1:0] reload_lp = cnt_w_lp'(dwell_cycles_p - 1);

  logic [cnt_w_lp-1:0] count_q;

  assign expired_o = en_i & ((count_q == '0) | end_i);

  // Count down while enabled; reload on clear or at terminal count.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= reload_lp;
    end else if (clear_i || expired_o) begin
      count_q <= reload_lp;
    end else if (en_i) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/matrix_io_ctrl.sv
// Matrix I/O controller: assembles serial operand bits into words for the
// array, collects results into a small buffer, then shows each result for a
// fixed dwell before starting the next job.
// Optional feature: define MATRIX_IO_CTRL_SKIP_EN to add skip_i, which cuts
// the current display dwell short.
//
// state      | meaning
// LOAD       | shifting in operand bits, handing words to the array
// COMPUTE    | all operands delivered, waiting for results
// DISPLAY    | stepping through buffered results, one dwell each
module matrix_io_ctrl
  import matrix_io_pkg::*;
#(
  parameter int width_p        = 8,
  parameter int num_operands_p = 8,
  parameter int num_results_p  = 4,
  parameter int dwell_cycles_p = 60000000
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  bit_valid_i,
  input  logic                                  bit_i,
  output logic                                  bit_ready_o,
  output logic                                  load_valid_o,
  output logic [width_p-1:0]                    load_data_o,
  input  logic                                  load_ready_i,
  input  logic                                  res_valid_i,
  input  logic [width_p-1:0]                    res_data_i,
  output logic                                  res_ready_o,
  output logic                                  disp_valid_o,
  output logic [width_p-1:0]                    disp_data_o,
  output logic [clog2_min1(num_results_p)-1:0]  disp_index_o,
`ifdef MATRIX_IO_CTRL_SKIP_EN
  input  logic                                  skip_i,
`endif
  input  logic                                  abort_i,
  output logic [1:0]                            phase_o
);

  localparam int ridx_w_lp = clog2_min1(num_results_p);
  localparam int bcnt_w_lp = $clog2(width_p + 1);
  localparam int wcnt_w_lp = $clog2(num_operands_p + 1);

  state_e                 state_q, state_d;
  logic [width_p-1:0]     shift_q;
  logic [bcnt_w_lp-1:0]   bit_cnt_q;
  logic                   pending_q;
  logic [wcnt_w_lp-1:0]   word_cnt_q;
  logic [width_p-1:0]     buf_q [num_results_p];
  logic [ridx_w_lp-1:0]   wr_idx_q;
  logic [ridx_w_lp-1:0]   disp_idx_q;

  logic in_load, in_display;
  logic bit_acc, load_xfer, res_wr;
  logic last_bit, last_word, last_res, last_idx;
  logic dwell_exp, dwell_end, job_done, clr_all;

  assign in_load    = (state_q == ST_LOAD);
  assign in_display = (state_q == ST_DISPLAY);

  assign bit_ready_o  = in_load & ~pending_q;
  assign load_valid_o = in_load & pending_q;
  assign load_data_o  = load_valid_o ? shift_q : '0;
  assign res_ready_o  = ~in_display;

  // abort_i wins over any handshake in the same cycle.
  assign bit_acc   = bit_valid_i & bit_ready_o & ~abort_i;
  assign load_xfer = load_valid_o & load_ready_i & ~abort_i;
  assign res_wr    = res_valid_i & res_ready_o & ~abort_i;

  assign last_bit  = (bit_cnt_q == bcnt_w_lp'(width_p - 1));
  assign last_word = (word_cnt_q == wcnt_w_lp'(num_operands_p - 1));
  assign last_res  = (wr_idx_q == ridx_w_lp'(num_results_p - 1));
  assign last_idx  = (disp_idx_q == ridx_w_lp'(num_results_p - 1));

  assign job_done = in_display & dwell_exp & last_idx;
  assign clr_all  = abort_i | job_done;

  assign disp_valid_o = in_display;
  assign disp_data_o  = in_display ? buf_q[disp_idx_q] : '0;
  assign disp_index_o = disp_idx_q;
  assign phase_o      = state_q;

`ifdef MATRIX_IO_CTRL_SKIP_EN
  assign dwell_end = skip_i;
`else
  assign dwell_end = 1'b0;
`endif

  dwell_timer #(
    .dwell_cycles_p(dwell_cycles_p)
  ) u_dwell_timer (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .en_i     (in_display),
    .clear_i  (~in_display | abort_i),
    .end_i    (dwell_end),
    .expired_o(dwell_exp)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= ST_LOAD;
    else            state_q <= state_d;
  end

  // Next-state: a full result buffer takes priority over finishing the load.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (res_wr && last_res)        state_d = ST_DISPLAY;
          else if (load_xfer && last_word) state_d = ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (res_wr && last_res) state_d = ST_DISPLAY;
        end
        ST_DISPLAY: begin
          if (job_done) state_d = ST_LOAD;
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // Bit assembly, pending word and operand word count.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clr_all) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      pending_q  <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      if (bit_acc) begin
        shift_q <= (shift_q << 1) | width_p'(bit_i);
        if (last_bit) begin
          bit_cnt_q <= '0;
          pending_q <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end
      if (load_xfer) begin
        pending_q  <= 1'b0;
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  // Result buffer; write index stops at the last slot since the FSM leaves
  // for DISPLAY on that write.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clr_all) begin
      for (int i = 0; i < num_results_p; i++) buf_q[i] <= '0;
      wr_idx_q <= '0;
    end else if (res_wr) begin
      buf_q[wr_idx_q] <= res_data_i;
      if (!last_res) wr_idx_q <= wr_idx_q + 1'b1;
    end
  end

  // Display index advances once per expired dwell.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clr_all) begin
      disp_idx_q <= '0;
    end else if (in_display && dwell_exp && !last_idx) begin
      disp_idx_q <= disp_idx_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_io_ctrl.sv
// Directed bench for matrix_io_ctrl (8-bit words, 2 operands, 2 results,
// 4-cycle dwell). Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_matrix_io_ctrl;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         bit_valid_i, bit_i, bit_ready_o;
  logic         load_valid_o, load_ready_i;
  logic [W-1:0] load_data_o;
  logic         res_valid_i, res_ready_o;
  logic [W-1:0] res_data_i;
  logic         disp_valid_o;
  logic [W-1:0] disp_data_o;
  logic [0:0]   disp_index_o;
  logic         abort_i;
  logic [1:0]   phase_o;
`ifdef MATRIX_IO_CTRL_SKIP_EN
  logic         skip_i;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  matrix_io_ctrl #(
    .width_p(8), .num_operands_p(2), .num_results_p(2), .dwell_cycles_p(4)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .bit_valid_i(bit_valid_i), .bit_i(bit_i), .bit_ready_o(bit_ready_o),
    .load_valid_o(load_valid_o), .load_data_o(load_data_o), .load_ready_i(load_ready_i),
    .res_valid_i(res_valid_i), .res_data_i(res_data_i), .res_ready_o(res_ready_o),
    .disp_valid_o(disp_valid_o), .disp_data_o(disp_data_o), .disp_index_o(disp_index_o),
`ifdef MATRIX_IO_CTRL_SKIP_EN
    .skip_i(skip_i),
`endif
    .abort_i(abort_i), .phase_o(phase_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid_i = 1'b1;
    bit_i       = b;
    tick();
    bit_valid_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    logic [7:0] t;
    t = v;
    for (int i = 7; i >= 0; i--) send_bit(t[i]);
  endtask

  task automatic send_res(input logic [7:0] v);
    res_valid_i = 1'b1;
    res_data_i  = v;
    tick();
    res_valid_i = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_phase"},  32'(phase_o), 32'd0);
    chk({tag, "_bready"}, 32'(bit_ready_o), 32'd1);
    chk({tag, "_lvalid"}, 32'(load_valid_o), 32'd0);
    chk({tag, "_ldata"},  32'(load_data_o), 32'd0);
    chk({tag, "_rready"}, 32'(res_ready_o), 32'd1);
    chk({tag, "_dvalid"}, 32'(disp_valid_o), 32'd0);
    chk({tag, "_ddata"},  32'(disp_data_o), 32'd0);
    chk({tag, "_didx"},   32'(disp_index_o), 32'd0);
  endtask

  initial begin
    reset_n_i = 1'b0; bit_valid_i = 1'b0; bit_i = 1'b0; load_ready_i = 1'b0;
    res_valid_i = 1'b0; res_data_i = '0; abort_i = 1'b0;
`ifdef MATRIX_IO_CTRL_SKIP_EN
    skip_i = 1'b0;
`endif
    tick(); tick();
    reset_n_i = 1'b1;
    chk_idle("reset");

    // First word 0xA5 with the array ready: one-cycle handshake.
    load_ready_i = 1'b1;
    send_byte(8'hA5);
    chk("w1_lvalid", 32'(load_valid_o), 32'd1);
    chk("w1_ldata",  32'(load_data_o), 32'hA5);
    chk("w1_bready", 32'(bit_ready_o), 32'd0);
    tick();
    chk("w1_lvalid_drop", 32'(load_valid_o), 32'd0);
    chk("w1_ldata_zero",  32'(load_data_o), 32'd0);
    chk("w1_bready_back", 32'(bit_ready_o), 32'd1);
    chk("w1_phase",       32'(phase_o), 32'd0);

    // Second word 0x3C held off by the array; offered bits must be dropped.
    load_ready_i = 1'b0;
    send_byte(8'h3C);
    for (int i = 0; i < 5; i++) begin
      chk("w2_hold_lvalid", 32'(load_valid_o), 32'd1);
      chk("w2_hold_ldata",  32'(load_data_o), 32'h3C);
      chk("w2_hold_bready", 32'(bit_ready_o), 32'd0);
      bit_valid_i = 1'b1; bit_i = 1'b1;
      tick();
    end
    bit_valid_i = 1'b0;
    chk("w2_still_3c", 32'(load_data_o), 32'h3C);
    load_ready_i = 1'b1;
    tick();
    load_ready_i = 1'b0;
    chk("w2_phase_compute", 32'(phase_o), 32'd1);
    chk("w2_lvalid",        32'(load_valid_o), 32'd0);
    chk("compute_bready",   32'(bit_ready_o), 32'd0);
    chk("compute_rready",   32'(res_ready_o), 32'd1);

    // Results 0x12, 0x34 then two 4-cycle dwells.
    send_res(8'h12);
    chk("r1_phase", 32'(phase_o), 32'd1);
    send_res(8'h34);
    chk("r2_phase_disp", 32'(phase_o), 32'd2);
    chk("disp_rready",   32'(res_ready_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("d0_valid", 32'(disp_valid_o), 32'd1);
      chk("d0_data",  32'(disp_data_o), 32'h12);
      chk("d0_idx",   32'(disp_index_o), 32'd0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk("d1_valid", 32'(disp_valid_o), 32'd1);
      chk("d1_data",  32'(disp_data_o), 32'h34);
      chk("d1_idx",   32'(disp_index_o), 32'd1);
      tick();
    end
    chk_idle("job_end");

    // Abort during the second display cycle.
    send_res(8'h56);
    send_res(8'h78);
    chk("ab_phase_disp", 32'(phase_o), 32'd2);
    chk("ab_d0_data",    32'(disp_data_o), 32'h56);
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("ab_phase",  32'(phase_o), 32'd0);
    chk("ab_rready", 32'(res_ready_o), 32'd1);
    chk("ab_dvalid", 32'(disp_valid_o), 32'd0);
    // A result offered together with abort must not be stored.
    abort_i = 1'b1;
    send_res(8'hEE);
    abort_i = 1'b0;
    chk("ab_hs_phase", 32'(phase_o), 32'd0);
    send_res(8'h9A);
    chk("nj_r1_phase", 32'(phase_o), 32'd0);
    send_res(8'hBC);
    chk("nj_phase_disp", 32'(phase_o), 32'd2);
    chk("nj_d0_data",    32'(disp_data_o), 32'h9A);
    chk("nj_d0_idx",     32'(disp_index_o), 32'd0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("nj_abort_phase", 32'(phase_o), 32'd0);

    // Reset part way through a word discards the partial bits.
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    chk_idle("mid_rst");
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("rst_no_early_pending", 32'(load_valid_o), 32'd0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    chk("rst_lvalid", 32'(load_valid_o), 32'd1);
    chk("rst_ldata",  32'(load_data_o), 32'hFF);

`ifdef MATRIX_IO_CTRL_SKIP_EN
    // Skip in the first dwell cycle of index 0 jumps to index 1.
    send_res(8'h11);
    send_res(8'h22);
    chk("sk_phase", 32'(phase_o), 32'd2);
    chk("sk_d0",    32'(disp_data_o), 32'h11);
    skip_i = 1'b1;
    tick();
    skip_i = 1'b0;
    chk("sk_idx1",  32'(disp_index_o), 32'd1);
    chk("sk_data1", 32'(disp_data_o), 32'h22);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_io_ctrl.md
MATRIX_IO_CTRL -- requirements
Module: matrix_io_ctrl

Interface
REQ-001 SHALL have parameters: width_p, 8, word width; num_operands_p, 8, words loaded per job; num_results_p, 4, results per job; dwell_cycles_p, 60000000, cycles each result is displayed.
REQ-002 SHALL have ports: clk_i in 1 clock; reset_n_i in 1 synchronous active-low reset, sampled on posedge clk_i.
REQ-003 SHALL have ports: bit_valid_i in 1, bit_i in 1 serial operand bit; bit_ready_o out 1.
REQ-004 SHALL have ports: load_valid_o out 1, load_data_o out width_p, load_ready_i in 1 (operand word to array).
REQ-005 SHALL have ports: res_valid_i in 1, res_data_i in width_p, res_ready_o out 1 (result from array).
REQ-006 SHALL have ports: disp_valid_o out 1, disp_data_o out width_p, disp_index_o out $clog2(num_results_p) (min 1), abort_i in 1, phase_o out 2 (current state encoding).

Function
REQ-007 SHALL implement states LOAD=0, COMPUTE=1, DISPLAY=2; LOAD follows reset.
REQ-008 SHALL, in LOAD with no pending word, assert bit_ready_o and shift bit_i into the LSB on each bit_valid_i; the first bit ends up as MSB.
REQ-009 SHALL mark a word pending after width_p accepted bits; pending drives load_valid_o=1 and load_data_o=word, with bit_ready_o=0; bits offered while bit_ready_o=0 are dropped.
REQ-010 SHALL complete a transfer on load_valid_o & load_ready_i; the next cycle clears pending and increments the word count; load_data_o holds stable while load_valid_o=1 and is 0 otherwise.
REQ-011 SHALL enter COMPUTE the cycle after the num_operands_p-th transfer; bit_ready_o=0 outside LOAD.
REQ-012 SHALL assert res_ready_o in LOAD and COMPUTE while the result buffer holds fewer than num_results_p entries; res_valid_i & res_ready_o writes res_data_i at the write index.
REQ-013 SHALL enter DISPLAY the cycle after the buffer becomes full, from LOAD or COMPUTE; res_ready_o=0 in DISPLAY.
REQ-014 SHALL, in DISPLAY, assert disp_valid_o and present buffer[idx] on disp_data_o and idx on disp_index_o for exactly dwell_cycles_p cycles per index, idx ascending from 0.
REQ-015 SHALL, after the last index's final dwell cycle, return to LOAD with the buffer, word count, bit count and idx cleared; disp_valid_o=0 and disp_data_o=0 outside DISPLAY.
REQ-016 SHALL make abort_i a synchronous return to LOAD from any state with all counters, pending and buffer cleared; abort_i overrides any same-cycle handshake (not counted/stored).
REQ-017 SHALL use a dwell counter wide enough for dwell_cycles_p-1; dwell_cycles_p=1 advances idx every cycle.

Reset
REQ-018 SHALL, while reset_n_i=0 at a clock edge, set state LOAD, clear all counters, shifter, pending and buffer.
REQ-019 SHALL present, after reset: bit_ready_o=1, load_valid_o=0, load_data_o=0, res_ready_o=1, disp_valid_o=0, disp_data_o=0, disp_index_o=0, phase_o=0; reset mid-DISPLAY discards contents.

Configuration
REQ-020 SHALL, with MATRIX_IO_CTRL_SKIP_EN defined, add input skip_i (1 bit): in DISPLAY, skip_i=1 ends the current dwell that cycle (next cycle advances idx or exits as if dwell expired).
REQ-021 SHALL, without MATRIX_IO_CTRL_SKIP_EN, omit skip_i entirely; dwell is fixed.

Structure
REQ-022 SHALL place the state enum typedef (2-bit) and phase encodings in package matrix_io_pkg.
REQ-023 SHALL instantiate one sub-module, dwell_timer (count/enable/clear, expired pulse); bit assembly and buffer stay inline.

Verification (width_p=8, num_operands_p=2, num_results_p=2, dwell_cycles_p=4)
REQ-024 SHALL check: bits 1,0,1,0,0,1,0,1 with load_ready_i=1 -> load_valid_o one cycle, load_data_o=0xA5.
REQ-025 SHALL check: load_ready_i=0 for 5 cycles after pending -> load_data_o stable, extra bits dropped, bit_ready_o=0; second transfer -> phase_o=1.
REQ-026 SHALL check: results 0x12, 0x34 -> phase_o=2 next cycle; disp_data_o=0x12 idx0 4 cycles, 0x34 idx1 4 cycles, then phase_o=0, disp_valid_o=0.
REQ-027 SHALL check: abort_i during second DISPLAY cycle -> next cycle phase_o=0, res_ready_o=1, subsequent result counted as first of new job.
REQ-028 SHALL check: reset_n_i=0 mid-LOAD after 3 bits, then full byte 0xFF -> load_data_o=0xFF (prior bits discarded).
REQ-029 SHALL check (SKIP_EN): skip_i pulse in first dwell cycle of idx0 -> idx1 on next cycle.
